// File: rtl/mac3_window_if.sv
// Streaming port bundle for mac3_window: the sample stream and controls going in,
// the registered result coming out.
interface mac3_window_if #(
    parameter int DATA_W = 32,
    parameter int OUT_W  = 32
);
    logic              validi;
    logic [DATA_W-1:0] data_in;
    logic [1:0]        mode;
    logic              clr;
    logic              valido;
    logic [OUT_W-1:0]  data_out;
    logic              ovf;

    // Producer side: drives samples and controls, observes results
    modport master (
        output validi, data_in, mode, clr,
        input  valido, data_out, ovf
    );

    // Datapath side: the mac3_window unit itself
    modport slave (
        input  validi, data_in, mode, clr,
        output valido, data_out, ovf
    );
endinterface

// File: rtl/mac3_window.sv
// Sliding-window three-operand multiply-add. Keeps the two previous samples
// (s2 oldest, s1 newest) and, once three consecutive valid samples have been
// seen, produces f(s2, s1, data_in) one cycle later, sliding by one sample per
// valid cycle. The arithmetic is done at full precision (2*DATA_W+2 bits) and
// then truncated to OUT_W bits, with ovf flagging a result that did not fit.
module mac3_window #(
    parameter int DATA_W = 32,
    parameter int OUT_W  = 32,
    parameter int SIGNED = 0
) (
    input  logic          clk,
    input  logic          rst,
    mac3_window_if.slave  bus
);
    localparam int FULL_W = 2 * DATA_W + 2;

    // Sign- or zero-extend one operand to the full-precision width
    function automatic logic [FULL_W-1:0] extend_op(input logic [DATA_W-1:0] v);
        logic [FULL_W-1:0] r;
        if (SIGNED != 0) begin
            r = {{(FULL_W - DATA_W){v[DATA_W-1]}}, v};
        end else begin
            r = {{(FULL_W - DATA_W){1'b0}}, v};
        end
        return r;
    endfunction

    logic [DATA_W-1:0] s1_r;
    logic [DATA_W-1:0] s2_r;
    logic [1:0]        run_r;
    logic              valido_r;
    logic [OUT_W-1:0]  data_out_r;
    logic              ovf_r;

    logic [FULL_W-1:0] a_ext_s;
    logic [FULL_W-1:0] b_ext_s;
    logic [FULL_W-1:0] c_ext_s;
    logic [FULL_W-1:0] full_s;
    logic [FULL_W-1:0] ext_s;
    logic              ovf_s;
    logic              compute_s;

    // A result is due when this sample is the third (or later) of an unbroken run
    always_comb begin
        compute_s = 1'b0;
        if (bus.validi && (run_r >= 2'd2)) begin
            compute_s = 1'b1;
        end else begin
            compute_s = 1'b0;
        end
    end

    // Full-precision evaluation of the selected operation on (s2, s1, data_in).
    // Operands are extended first, so the low FULL_W bits of the product are exact
    // for both signed and unsigned interpretation.
    always_comb begin
        a_ext_s = extend_op(s2_r);
        b_ext_s = extend_op(s1_r);
        c_ext_s = extend_op(bus.data_in);
        full_s  = {FULL_W{1'b0}};
        case (bus.mode)
            2'b00:   full_s = (a_ext_s * b_ext_s) + c_ext_s;
            2'b01:   full_s = (a_ext_s * b_ext_s) - c_ext_s;
            2'b10:   full_s = a_ext_s * b_ext_s;
            2'b11:   full_s = a_ext_s + b_ext_s + c_ext_s;
            default: full_s = {FULL_W{1'b0}};
        endcase
    end

    // Re-extend the truncated result; any difference from the full value means
    // it did not fit in OUT_W (a negative unsigned difference lands here too)
    always_comb begin
        ext_s = full_s;
        for (int i = 0; i < FULL_W; i++) begin
            if (i >= OUT_W) begin
                ext_s[i] = (SIGNED != 0) ? full_s[OUT_W-1] : 1'b0;
            end else begin
                ext_s[i] = full_s[i];
            end
        end
        ovf_s = (ext_s != full_s);
    end

    // Window, run counter and registered outputs; rst beats clr beats validi
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r       <= {DATA_W{1'b0}};
            s2_r       <= {DATA_W{1'b0}};
            run_r      <= 2'd0;
            valido_r   <= 1'b0;
            data_out_r <= {OUT_W{1'b0}};
            ovf_r      <= 1'b0;
        end else if (bus.clr) begin
            // Flush: discard this cycle's sample, keep the last result visible
            run_r    <= 2'd0;
            valido_r <= 1'b0;
        end else if (bus.validi) begin
            s2_r     <= s1_r;
            s1_r     <= bus.data_in;
            run_r    <= (run_r == 2'd3) ? 2'd3 : (run_r + 2'd1);
            valido_r <= compute_s;
            if (compute_s) begin
                data_out_r <= full_s[OUT_W-1:0];
                ovf_r      <= ovf_s;
            end else begin
                data_out_r <= data_out_r;
                ovf_r      <= ovf_r;
            end
        end else begin
            // A gap breaks the run; stale window contents are never used
            run_r    <= 2'd0;
            valido_r <= 1'b0;
        end
    end

    assign bus.valido   = valido_r;
    assign bus.data_out = data_out_r;
    assign bus.ovf      = ovf_r;
endmodule

// File: tb/tb_mac3_window.sv
// Bench for mac3_window: three instances (32/32 unsigned, 8/8 unsigned,
// 8/16 signed) share one stimulus stream. A window model pushes expected
// results into a scoreboard when a third-in-a-row sample is driven; they are
// popped and compared when the outputs of that edge are sampled.
module tb_mac3_window;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mac3_window_if #(.DATA_W(32), .OUT_W(32)) if0 ();
    mac3_window_if #(.DATA_W(8),  .OUT_W(8))  if1 ();
    mac3_window_if #(.DATA_W(8),  .OUT_W(16)) if2 ();

    mac3_window #(.DATA_W(32), .OUT_W(32), .SIGNED(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    mac3_window #(.DATA_W(8),  .OUT_W(8),  .SIGNED(0)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    mac3_window #(.DATA_W(8),  .OUT_W(16), .SIGNED(1)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    logic [31:0] got_d [3];
    logic        got_o [3];
    logic        got_v [3];

    assign got_d[0] = if0.data_out;
    assign got_d[1] = {24'd0, if1.data_out};
    assign got_d[2] = {16'd0, if2.data_out};
    assign got_o[0] = if0.ovf;
    assign got_o[1] = if1.ovf;
    assign got_o[2] = if2.ovf;
    assign got_v[0] = if0.valido;
    assign got_v[1] = if1.valido;
    assign got_v[2] = if2.valido;

    int n_cmp = 0;
    int n_err = 0;

    // Window model state
    logic [31:0]      m_s1   = 32'd0;
    logic [31:0]      m_s2   = 32'd0;
    int               m_run  = 0;
    logic             exp_vld = 1'b0;
    logic [32:0]      cur [3] = '{33'd0, 33'd0, 33'd0};
    logic [2:0][32:0] sb [$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Keep the low w bits of v, sign-extending them when sg is set
    function automatic logic signed [127:0] sx(input logic [127:0] v, input int w, input bit sg);
        logic [127:0] mask;
        logic [127:0] r;
        mask = (128'd1 << w) - 128'd1;
        r = v & mask;
        if (sg && r[w-1]) r = r | ~mask;
        return r;
    endfunction

    // Reference result {ovf, data_out} at 128-bit precision
    function automatic logic [32:0] ref_mac(input int dw, input int ow, input bit sg,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c, input logic [1:0] m);
        logic signed [127:0] ea, eb, ec, full, ext, tr;
        ea = sx({96'd0, a}, dw, sg);
        eb = sx({96'd0, b}, dw, sg);
        ec = sx({96'd0, c}, dw, sg);
        case (m)
            2'b00:   full = ea * eb + ec;
            2'b01:   full = ea * eb - ec;
            2'b10:   full = ea * eb;
            default: full = ea + eb + ec;
        endcase
        ext = sx(full, ow, sg);
        tr  = sx(full, ow, 1'b0);
        return {(ext != full), tr[31:0]};
    endfunction

    // One clock: check what the previous edge produced, then drive the next cycle
    task automatic step(input logic v, input logic [31:0] d, input logic [1:0] m,
                        input logic c, input logic r);
        logic [2:0][32:0] e;
        @(posedge clk);
        #1;
        if (exp_vld && (sb.size() > 0)) begin
            e = sb.pop_front();
            for (int k = 0; k < 3; k++) cur[k] = e[k];
        end
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("valido%0d", k), {63'd0, got_v[k]}, {63'd0, exp_vld});
            check_val($sformatf("data_out%0d", k), {32'd0, got_d[k]}, {32'd0, cur[k][31:0]});
            check_val($sformatf("ovf%0d", k), {63'd0, got_o[k]}, {63'd0, cur[k][32]});
        end
        rst = r;
        if0.validi = v; if0.data_in = d;      if0.mode = m; if0.clr = c;
        if1.validi = v; if1.data_in = d[7:0]; if1.mode = m; if1.clr = c;
        if2.validi = v; if2.data_in = d[7:0]; if2.mode = m; if2.clr = c;
        exp_vld = 1'b0;
        if (r) begin
            m_run = 0; m_s1 = 32'd0; m_s2 = 32'd0;
            for (int k = 0; k < 3; k++) cur[k] = 33'd0;
            sb.delete();
        end else if (c) begin
            m_run = 0;
        end else if (v) begin
            if (m_run >= 2) begin
                e[0] = ref_mac(32, 32, 1'b0, m_s2, m_s1, d, m);
                e[1] = ref_mac(8,  8,  1'b0, m_s2, m_s1, d, m);
                e[2] = ref_mac(8,  16, 1'b1, m_s2, m_s1, d, m);
                sb.push_back(e);
                exp_vld = 1'b1;
            end
            m_s2 = m_s1;
            m_s1 = d;
            m_run = (m_run == 3) ? 3 : m_run + 1;
        end else begin
            m_run = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        if0.validi = 1'b1; if0.data_in = 32'd0; if0.mode = 2'b00; if0.clr = 1'b0;
        if1.validi = 1'b1; if1.data_in = 8'd0;  if1.mode = 2'b00; if1.clr = 1'b0;
        if2.validi = 1'b1; if2.data_in = 8'd0;  if2.mode = 2'b00; if2.clr = 1'b0;

        // Reset held with validi high, then 2,3,4 -> 10
        step(1'b1, 32'd7, 2'b00, 1'b0, 1'b1);
        step(1'b1, 32'd7, 2'b00, 1'b0, 1'b1);
        step(1'b1, 32'd2, 2'b00, 1'b0, 1'b0);
        step(1'b1, 32'd3, 2'b00, 1'b0, 1'b0);
        step(1'b1, 32'd4, 2'b00, 1'b0, 1'b0);
        idle(2);

        // Sliding window 2..6 -> 10, 17, 26
        for (int i = 2; i <= 6; i++) step(1'b1, i, 2'b00, 1'b0, 1'b0);
        idle(1);

        // Gaps: runs of 2 never fire; 7,8,9 -> 65 and then holds
        step(1'b1, 32'd1, 2'b00, 1'b0, 1'b0);
        step(1'b1, 32'd1, 2'b00, 1'b0, 1'b0);
        idle(1);
        step(1'b1, 32'd1, 2'b00, 1'b0, 1'b0);
        step(1'b1, 32'd1, 2'b00, 1'b0, 1'b0);
        idle(1);
        step(1'b1, 32'd7, 2'b00, 1'b0, 1'b0);
        step(1'b1, 32'd8, 2'b00, 1'b0, 1'b0);
        step(1'b1, 32'd9, 2'b00, 1'b0, 1'b0);
        idle(3);

        // Modes and overflow
        step(1'b1, 32'd16, 2'b00, 1'b0, 1'b0);
        step(1'b1, 32'd16, 2'b00, 1'b0, 1'b0);
        step(1'b1, 32'd1,  2'b00, 1'b0, 1'b0);
        idle(1);
        step(1'b1, 32'd2,  2'b01, 1'b0, 1'b0);
        step(1'b1, 32'd3,  2'b01, 1'b0, 1'b0);
        step(1'b1, 32'd10, 2'b01, 1'b0, 1'b0);
        idle(1);
        step(1'b1, 32'd3, 2'b11, 1'b0, 1'b0);
        step(1'b1, 32'd4, 2'b11, 1'b0, 1'b0);
        step(1'b1, 32'd5, 2'b11, 1'b0, 1'b0);
        step(1'b1, 32'd6, 2'b10, 1'b0, 1'b0);
        idle(1);

        // Signed -3, 5, -2 -> -17
        step(1'b1, 32'hFFFF_FFFD, 2'b00, 1'b0, 1'b0);
        step(1'b1, 32'd5,         2'b00, 1'b0, 1'b0);
        step(1'b1, 32'hFFFF_FFFE, 2'b00, 1'b0, 1'b0);
        idle(1);

        // clr on the third sample discards it; three fresh samples needed
        step(1'b1, 32'd1, 2'b00, 1'b0, 1'b0);
        step(1'b1, 32'd2, 2'b00, 1'b0, 1'b0);
        step(1'b1, 32'd3, 2'b00, 1'b1, 1'b0);
        step(1'b1, 32'd4, 2'b00, 1'b0, 1'b0);
        step(1'b1, 32'd5, 2'b00, 1'b0, 1'b0);
        step(1'b1, 32'd6, 2'b00, 1'b0, 1'b0);

        // rst on a computing cycle wins; outputs go to zero
        step(1'b1, 32'd7, 2'b00, 1'b0, 1'b1);
        step(1'b1, 32'd1, 2'b00, 1'b0, 1'b0);
        step(1'b1, 32'd2, 2'b00, 1'b0, 1'b0);
        step(1'b1, 32'd3, 2'b00, 1'b0, 1'b1);
        idle(2);

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 9) != 0, $urandom, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0);
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mac3_window.md
# mac3_window

Sliding-window three-operand multiply-add unit, parametrised in operand width, output width and signedness, with a run-time operation select and an overflow flag. It sits on the streaming datapath behind any producer that drives validi/data_in. Once three consecutive valid samples a, b, c have been seen, it produces a registered result every valid cycle, with the window sliding by one sample each time. It is the generalised successor of the fixed 32-bit a*b+c stage.

## Interface
- DATA_W, 32, operand width in bits (≥2)
- OUT_W, 32, result width in bits (DATA_W ≤ OUT_W ≤ 2*DATA_W+2)
- SIGNED, 0, 0 = unsigned operands/result, 1 = two's-complement
- clk  in  1  rising-edge clock; single clock domain
- rst  in  1  reset, synchronous and active-high
- validi  in  1  data_in carries a sample this cycle
- data_in  in  DATA_W  input sample
- mode  in  2  operation select, sampled together with the c operand
- clr  in  1  synchronous window flush (not a full reset)
- valido  out  1  data_out/ovf valid this cycle
- data_out  out  OUT_W  registered result
- ovf  out  1  result did not fit in OUT_W (valid with valido)

## Operation
- Window registers s2 (oldest), s1, and a saturating run counter run ∈ {0,1,2,3}.
- On each validi=1 cycle:
  - the sample shifts in (s2←s1, s1←data_in);
  - run increments, saturating at 3 (run counts the current sample).
- A validi=0 cycle sets run←0. The window registers keep their values, but these are never used before three new samples arrive.
- Compute on a cycle where validi=1 and run (before increment) ≥ 2: a=s2, b=s1, c=data_in.
- Modes:
  - 00: a*b+c
  - 01: a*b−c
  - 10: a*b
  - 11: a+b+c
- Arithmetic width rules:
  - The full-precision result uses 2*DATA_W+2 bits, with operands sign- or zero-extended per SIGNED.
  - data_out takes the low OUT_W bits, i.e. modulo 2^OUT_W.
  - ovf=1 iff the full result ≠ the extension of the truncated value.
  - Unsigned mode 01 with a*b < c gives ovf=1, and data_out takes the wrapped value.
- Non-compute cycles:
  - valido=0;
  - data_out and ovf hold their last value (not zeroed).
- clr=1: run←0 and valido←0 next cycle; data_out and ovf hold. clr has priority over validi in the same cycle, so that sample is discarded.
- rst=1: run←0, s1/s2←0, valido←0, data_out←0, ovf←0. rst has priority over clr and validi.
- Mid-window reset: any run in progress is lost, and three fresh valid samples are needed after rst deasserts.

## Timing
- Latency: result appears the cycle after the c sample (one register stage).
- Samples A, B, C at cycles t0, t1, t2 → valido=1 at t3 with data_out = f(A,B,C), where mode is the value sampled at t2.
- Continued validi at t3 with D → valido=1 at t4 with f(B,C,D). Throughput is one result per cycle while validi is held.
- Output is a function of data_in at t−3, t−2 and t−1 whenever valido=1.
- Any single validi=0 gap restarts the count: at least 3 further valid cycles are needed before the next valido.
- Runs of 1 or 2 valid cycles never produce valido.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset values of all outputs are 0. While rst is held, outputs stay 0 every cycle.

## Test plan
- Reset, unsigned: rst for 2 cycles with validi=1 → valido=0, data_out=0, ovf=0 throughout. Then 3 samples 2, 3, 4 with mode=00 → one cycle later valido=1, data_out=10.
- Sliding window: samples 2, 3, 4, 5, 6 held valid with mode=00 → valido on 3 consecutive cycles with data_out 10, 17, 26.
- Gap handling: valid 1, 1, gap, 1, 1, gap, then 7, 8, 9 → valido only after 9, with data_out=65. No valido after the runs of 1 or 2. data_out holds 65 afterwards with valido=0.
- Overflow and modes, DATA_W=8, OUT_W=8, unsigned:
  - 16, 16, 1 mode=00 → data_out=1, ovf=1;
  - 2, 3, 10 mode=01 → data_out=252, ovf=1;
  - 3, 4, 5 mode=11 → data_out=12, ovf=0.
- Signed, SIGNED=1, DATA_W=8, OUT_W=16: −3, 5, −2 mode=00 → data_out=−17 (0xFFEF), ovf=0.
- Priority: clr asserted on the 3rd sample → no valido, and 3 new samples are needed. rst asserted on the cycle valido would fire → valido=0, data_out=0 next cycle.
